// File: rtl/rv64g_tl_pkg.sv
// rv64g_tl_pkg
// Shared TileLink-C constants for the L1 client agent: channel opcodes,
// permission-transfer param encodings, the L1 permission enum and line
// geometry, plus two helpers used by the probe path to derive the new
// permission and the report param.
package rv64g_tl_pkg;

  // Channel opcodes
  localparam logic [2:0] TL_A_ACQUIRE_BLOCK  = 3'd6;
  localparam logic [2:0] TL_B_PROBE          = 3'd6;
  localparam logic [2:0] TL_C_PROBE_ACK      = 3'd4;
  localparam logic [2:0] TL_C_PROBE_ACK_DATA = 3'd5;
  localparam logic [2:0] TL_D_GRANT          = 3'd4;
  localparam logic [2:0] TL_D_GRANT_DATA     = 3'd5;
  // E carries no opcode field; the value only names the message.
  localparam logic [2:0] TL_E_GRANT_ACK      = 3'd0;

  // Grow params (Acquire)
  localparam logic [2:0] GROW_NTOB = 3'd0;
  localparam logic [2:0] GROW_NTOT = 3'd1;
  localparam logic [2:0] GROW_BTOT = 3'd2;

  // Cap params (Probe)
  localparam logic [1:0] CAP_TOT = 2'd0;
  localparam logic [1:0] CAP_TOB = 2'd1;
  localparam logic [1:0] CAP_TON = 2'd2;

  // Shrink/report params (ProbeAck)
  localparam logic [2:0] RPT_TTOB = 3'd0;
  localparam logic [2:0] RPT_TTON = 3'd1;
  localparam logic [2:0] RPT_BTON = 3'd2;
  localparam logic [2:0] RPT_TTOT = 3'd3;
  localparam logic [2:0] RPT_BTOB = 3'd4;
  localparam logic [2:0] RPT_NTON = 3'd5;

  // L1 permission, ordered so that a numeric min() is a permission min()
  typedef enum logic [1:0] {
    PERM_N = 2'd0,
    PERM_B = 2'd1,
    PERM_T = 2'd2
  } perm_e;

  localparam int BEATS_PER_LINE = 8;

  // Highest permission a probe cap leaves behind; unknown caps invalidate.
  function automatic perm_e cap_to_perm(input logic [1:0] cap);
    case (cap)
      CAP_TOT: return PERM_T;
      CAP_TOB: return PERM_B;
      default: return PERM_N;
    endcase
  endfunction

  // Report param describing the transition cur -> nxt.
  function automatic logic [2:0] report_param(input perm_e cur, input perm_e nxt);
    logic [2:0] rpt;
    rpt = RPT_NTON;
    case (cur)
      PERM_T: begin
        case (nxt)
          PERM_T:  rpt = RPT_TTOT;
          PERM_B:  rpt = RPT_TTOB;
          default: rpt = RPT_TTON;
        endcase
      end
      PERM_B:  rpt = (nxt == PERM_B) ? RPT_BTOB : RPT_BTON;
      default: rpt = RPT_NTON;
    endcase
    return rpt;
  endfunction

endpackage

// File: rtl/rv64g_l1_tl_client_if.sv
// rv64g_l1_tl_client_if
// TileLink-C link between an L1 client agent and the L2 crossbar (A..E).
// master: client side (drives A, C, E and the B/D ready signals).
// slave:  manager side (drives B, D and the A/C/E ready signals).
interface rv64g_l1_tl_client_if #(
  parameter int ADDR_W   = 64,
  parameter int DATA_W   = 64,
  parameter int SOURCE_W = 6
);
  logic [2:0]          a_opcode;
  logic [2:0]          a_param;
  logic [SOURCE_W-1:0] a_source;
  logic [ADDR_W-1:0]   a_address;
  logic                a_valid;
  logic                a_ready;

  logic [2:0]          b_opcode;
  logic [2:0]          b_param;
  logic [ADDR_W-1:0]   b_address;
  logic                b_valid;
  logic                b_ready;

  logic [2:0]          c_opcode;
  logic [2:0]          c_param;
  logic [SOURCE_W-1:0] c_source;
  logic [ADDR_W-1:0]   c_address;
  logic [DATA_W-1:0]   c_data;
  logic                c_valid;
  logic                c_ready;

  logic [2:0]          d_opcode;
  logic [1:0]          d_param;
  logic [DATA_W-1:0]   d_data;
  logic [SOURCE_W-1:0] d_source;
  logic [1:0]          d_sink;
  logic                d_valid;
  logic                d_ready;

  logic                e_valid;
  logic [1:0]          e_sink;
  logic                e_ready;

  modport master (
    output a_opcode, a_param, a_source, a_address, a_valid,
    input  a_ready,
    input  b_opcode, b_param, b_address, b_valid,
    output b_ready,
    output c_opcode, c_param, c_source, c_address, c_data, c_valid,
    input  c_ready,
    input  d_opcode, d_param, d_data, d_source, d_sink, d_valid,
    output d_ready,
    output e_valid, e_sink,
    input  e_ready
  );

  modport slave (
    input  a_opcode, a_param, a_source, a_address, a_valid,
    output a_ready,
    output b_opcode, b_param, b_address, b_valid,
    input  b_ready,
    input  c_opcode, c_param, c_source, c_address, c_data, c_valid,
    output c_ready,
    output d_opcode, d_param, d_data, d_source, d_sink, d_valid,
    input  d_ready,
    input  e_valid, e_sink,
    output e_ready
  );
endinterface

// File: rtl/rv64g_l1_tl_probe_unit.sv
// rv64g_l1_tl_probe_unit
// Answers B-channel Probes: looks up the L1 line, writes the capped
// permission back, and replies on C with ProbeAck or an 8-beat ProbeAckData.
// Ports:
//   clk_i, rst_ni          clock, async active-low reset
//   b_*_i / b_ready_o      B channel (manager -> client)
//   c_*_o / c_ready_i      C channel (client -> manager)
//   prb_*                  L1 lookup, data read and state-update port
//   err_o                  combinational strobe: non-Probe B message consumed
module rv64g_l1_tl_probe_unit
  import rv64g_tl_pkg::*;
#(
  parameter int                  ADDR_W   = 64,
  parameter int                  DATA_W   = 64,
  parameter int                  SOURCE_W = 6,
  parameter logic [SOURCE_W-1:0] SRC      = '0
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [2:0]          b_opcode_i,
  input  logic [2:0]          b_param_i,
  input  logic [ADDR_W-1:0]   b_address_i,
  input  logic                b_valid_i,
  output logic                b_ready_o,
  output logic [2:0]          c_opcode_o,
  output logic [2:0]          c_param_o,
  output logic [SOURCE_W-1:0] c_source_o,
  output logic [ADDR_W-1:0]   c_address_o,
  output logic [DATA_W-1:0]   c_data_o,
  output logic                c_valid_o,
  input  logic                c_ready_i,
  output logic [ADDR_W-1:0]   prb_addr_o,
  input  logic [1:0]          prb_perm_i,
  input  logic                prb_dirty_i,
  output logic [2:0]          prb_word_o,
  input  logic [DATA_W-1:0]   prb_data_i,
  output logic                prb_upd_o,
  output logic [1:0]          prb_new_perm_o,
  output logic                err_o
);

  localparam logic [2:0] LAST_BEAT = 3'(BEATS_PER_LINE - 1);

  typedef enum logic [1:0] {P_IDLE, P_LOOK, P_ACK, P_DATA} pstate_e;

  pstate_e           r_state, w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_cap;
  logic [2:0]        r_report, r_beat;
  perm_e             w_cur, w_cap, w_new;
  logic              w_unused;

  // The L1 never reports the reserved encoding 3; treat it as Trunk so a
  // corrupted lookup still gets downgraded rather than silently kept.
  assign w_cur = (prb_perm_i == 2'd3) ? PERM_T : perm_e'(prb_perm_i);
  assign w_cap = cap_to_perm(r_cap);
  assign w_new = (w_cur < w_cap) ? w_cur : w_cap;

  // Captures the probe, the report param computed in P_LOOK, and the data
  // beat counter, which only moves when the manager takes a beat.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= P_IDLE;
      r_addr   <= '0;
      r_cap    <= '0;
      r_report <= '0;
      r_beat   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == P_IDLE && b_valid_i && b_opcode_i == TL_B_PROBE) begin
        r_addr <= b_address_i;
        r_cap  <= b_param_i[1:0];
      end
      if (r_state == P_LOOK) begin
        r_report <= report_param(w_cur, w_new);
        r_beat   <= '0;
      end else if (r_state == P_DATA && c_ready_i) begin
        r_beat <= r_beat + 3'd1;
      end
    end
  end

  // Next state and handshake outputs; only dirty Trunk lines carry data.
  always_comb begin
    w_next     = r_state;
    b_ready_o  = 1'b0;
    c_valid_o  = 1'b0;
    c_opcode_o = TL_C_PROBE_ACK;
    prb_upd_o  = 1'b0;
    err_o      = 1'b0;
    case (r_state)
      P_IDLE: begin
        b_ready_o = 1'b1;
        if (b_valid_i) begin
          if (b_opcode_i == TL_B_PROBE) w_next = P_LOOK;
          else                          err_o  = 1'b1;
        end
      end
      P_LOOK: begin
        prb_upd_o = 1'b1;
        w_next    = (prb_dirty_i && w_cur == PERM_T) ? P_DATA : P_ACK;
      end
      P_ACK: begin
        c_valid_o = 1'b1;
        if (c_ready_i) w_next = P_IDLE;
      end
      P_DATA: begin
        c_valid_o  = 1'b1;
        c_opcode_o = TL_C_PROBE_ACK_DATA;
        if (c_ready_i && r_beat == LAST_BEAT) w_next = P_IDLE;
      end
      default: w_next = P_IDLE;
    endcase
  end

  assign c_param_o      = r_report;
  assign c_source_o     = SRC;
  assign c_address_o    = r_addr;
  assign c_data_o       = (r_state == P_DATA) ? prb_data_i : '0;
  assign prb_addr_o     = r_addr;
  assign prb_word_o     = r_beat;
  assign prb_new_perm_o = w_new;
  assign w_unused       = b_param_i[2];

endmodule

// File: rtl/rv64g_l1_tl_client.sv
// rv64g_l1_tl_client
// Per-core TileLink-C client agent between the L1 data cache and the L2
// crossbar. Runs one AcquireBlock at a time (A -> D refill -> E GrantAck)
// while the probe unit answers B-channel Probes concurrently.
// Ports:
//   clk_i, rst_ni          clock, async active-low reset
//   req_*                  L1 miss request
//   refill_*               refill beats to the L1
//   done_valid_o/perm_o    Acquire complete, granted cap (0=T, 1=B)
//   err_o                  one-cycle protocol error pulse (registered)
//   tl                     TileLink A..E channels (master modport)
//   prb_*                  L1 probe lookup/data/update port
// Optional: define L1_TL_GRANT_TIMEOUT_EN to flag a Grant that never arrives.
module rv64g_l1_tl_client
  import rv64g_tl_pkg::*;
#(
  parameter int ADDR_W    = 64,
  parameter int DATA_W    = 64,
  parameter int SOURCE_W  = 6,
  parameter int CID_W     = 2,
  parameter int CLIENT_ID = 0
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic [ADDR_W-1:0]  req_addr_i,
  input  logic               req_need_t_i,
  input  logic               req_have_b_i,
  output logic               refill_valid_o,
  output logic [2:0]         refill_word_o,
  output logic [DATA_W-1:0]  refill_data_o,
  output logic               done_valid_o,
  output logic [1:0]         done_perm_o,
  output logic               err_o,
  rv64g_l1_tl_client_if.master tl,
  output logic [ADDR_W-1:0]  prb_addr_o,
  input  logic [1:0]         prb_perm_i,
  input  logic               prb_dirty_i,
  output logic [2:0]         prb_word_o,
  input  logic [DATA_W-1:0]  prb_data_i,
  output logic               prb_upd_o,
  output logic [1:0]         prb_new_perm_o
);

  localparam logic [CID_W-1:0]    CID       = CID_W'(CLIENT_ID);
  localparam logic [SOURCE_W-1:0] SRC       = {CID, {(SOURCE_W-CID_W){1'b0}}};
  localparam logic [2:0]          LAST_BEAT = 3'(BEATS_PER_LINE - 1);

  typedef enum logic [1:0] {A_IDLE, A_REQ, A_GNT, A_ACK} astate_e;

  astate_e           r_state, w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [2:0]        r_param, r_beat;
  logic [1:0]        r_sink;
  logic              r_dperm, r_err;
  logic              w_latch, w_finish, w_beat_inc, w_acq_err, w_prb_err, w_tmo_err;
  logic              w_req_ready, w_a_valid, w_d_ready, w_e_valid, w_refill, w_done;
  logic              w_unused;

  // Request capture, refill beat counter, and the granted sink/cap that the
  // GrantAck and completion report need after the D burst has gone.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= A_IDLE;
      r_addr  <= '0;
      r_param <= '0;
      r_beat  <= '0;
      r_sink  <= '0;
      r_dperm <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_latch) begin
        r_addr  <= {req_addr_i[ADDR_W-1:6], 6'b0};
        r_param <= !req_need_t_i ? GROW_NTOB : (req_have_b_i ? GROW_BTOT : GROW_NTOT);
      end
      if (w_finish) begin
        r_sink  <= tl.d_sink;
        r_dperm <= tl.d_param[0];
        r_beat  <= '0;
      end else if (w_beat_inc) begin
        r_beat <= r_beat + 3'd1;
      end
      r_err <= w_acq_err | w_prb_err | w_tmo_err;
    end
  end

  // Acquire FSM next state and strobes. A dataless Grant only completes an
  // upgrade from Branch; anywhere else it is treated like a bad opcode.
  always_comb begin
    w_next      = r_state;
    w_req_ready = 1'b0;
    w_a_valid   = 1'b0;
    w_d_ready   = 1'b0;
    w_e_valid   = 1'b0;
    w_refill    = 1'b0;
    w_done      = 1'b0;
    w_latch     = 1'b0;
    w_finish    = 1'b0;
    w_beat_inc  = 1'b0;
    w_acq_err   = 1'b0;
    case (r_state)
      A_IDLE: begin
        w_req_ready = 1'b1;
        if (req_valid_i) begin
          w_latch = 1'b1;
          w_next  = A_REQ;
        end
      end
      A_REQ: begin
        w_a_valid = 1'b1;
        if (tl.a_ready) w_next = A_GNT;
      end
      A_GNT: begin
        w_d_ready = 1'b1;
        if (tl.d_valid) begin
          if (tl.d_opcode == TL_D_GRANT_DATA) begin
            w_refill   = 1'b1;
            w_beat_inc = 1'b1;
            if (r_beat == LAST_BEAT) begin
              w_finish = 1'b1;
              w_next   = A_ACK;
            end
          end else if (tl.d_opcode == TL_D_GRANT && r_param == GROW_BTOT && r_beat == 3'd0) begin
            w_finish = 1'b1;
            w_next   = A_ACK;
          end else begin
            w_acq_err = 1'b1;
          end
        end
      end
      A_ACK: begin
        w_e_valid = 1'b1;
        if (tl.e_ready) begin
          w_done = 1'b1;
          w_next = A_IDLE;
        end
      end
      default: w_next = A_IDLE;
    endcase
  end

`ifdef L1_TL_GRANT_TIMEOUT_EN
  logic [15:0] r_tmo;

  // Counts idle A_GNT cycles; sits at all-ones once the timeout has fired.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                           r_tmo <= '0;
    else if (r_state != A_GNT)             r_tmo <= '0;
    else if (!tl.d_valid && r_tmo != 16'hFFFF) r_tmo <= r_tmo + 16'd1;
  end

  assign w_tmo_err = (r_state == A_GNT) && !tl.d_valid && (r_tmo == 16'hFFFE);
`else
  assign w_tmo_err = 1'b0;
`endif

  assign req_ready_o    = w_req_ready;
  assign refill_valid_o = w_refill;
  assign refill_word_o  = r_beat;
  assign refill_data_o  = tl.d_data;
  assign done_valid_o   = w_done;
  assign done_perm_o    = {1'b0, r_dperm};
  assign err_o          = r_err;

  assign tl.a_valid   = w_a_valid;
  assign tl.a_opcode  = TL_A_ACQUIRE_BLOCK;
  assign tl.a_param   = r_param;
  assign tl.a_source  = SRC;
  assign tl.a_address = r_addr;
  assign tl.d_ready   = w_d_ready;
  assign tl.e_valid   = w_e_valid;
  assign tl.e_sink    = r_sink;

  assign w_unused = ^{req_addr_i[5:0], tl.d_source, tl.d_param[1]};

  rv64g_l1_tl_probe_unit #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .SOURCE_W (SOURCE_W),
    .SRC      (SRC)
  ) u_probe (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .b_opcode_i     (tl.b_opcode),
    .b_param_i      (tl.b_param),
    .b_address_i    (tl.b_address),
    .b_valid_i      (tl.b_valid),
    .b_ready_o      (tl.b_ready),
    .c_opcode_o     (tl.c_opcode),
    .c_param_o      (tl.c_param),
    .c_source_o     (tl.c_source),
    .c_address_o    (tl.c_address),
    .c_data_o       (tl.c_data),
    .c_valid_o      (tl.c_valid),
    .c_ready_i      (tl.c_ready),
    .prb_addr_o     (prb_addr_o),
    .prb_perm_i     (prb_perm_i),
    .prb_dirty_i    (prb_dirty_i),
    .prb_word_o     (prb_word_o),
    .prb_data_i     (prb_data_i),
    .prb_upd_o      (prb_upd_o),
    .prb_new_perm_o (prb_new_perm_o),
    .err_o          (w_prb_err)
  );

endmodule
